// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: instruction layout,
// opcode numbers, one-hot ALU operation codes and FSM state encodings.
package alu_issue_ctrl_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned FIELD_W = 4;
    localparam int unsigned OP_W    = 8;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Base opcode numbers (low three opcode bits)
    localparam logic [2:0] OPC_ADD = 3'd0;
    localparam logic [2:0] OPC_AND = 3'd1;
    localparam logic [2:0] OPC_OR  = 3'd2;
    localparam logic [2:0] OPC_NOT = 3'd3;
    localparam logic [2:0] OPC_XOR = 3'd4;
    localparam logic [2:0] OPC_SL  = 3'd5;
    localparam logic [2:0] OPC_SR  = 3'd6;
    localparam logic [2:0] OPC_CMP = 3'd7;

    // One-hot operation codes understood by the ALU
    localparam logic [OP_W-1:0] OP_NONE = 8'h00;
    localparam logic [OP_W-1:0] OP_ADD  = 8'h01;
    localparam logic [OP_W-1:0] OP_AND  = 8'h02;
    localparam logic [OP_W-1:0] OP_OR   = 8'h04;
    localparam logic [OP_W-1:0] OP_NOT  = 8'h08;
    localparam logic [OP_W-1:0] OP_XOR  = 8'h10;
    localparam logic [OP_W-1:0] OP_SL   = 8'h20;
    localparam logic [OP_W-1:0] OP_SR   = 8'h40;
    localparam logic [OP_W-1:0] OP_CMP  = 8'h80;

    // Instruction word: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb
    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [FIELD_W-1:0] rd;
        logic [FIELD_W-1:0] ra;
        logic [FIELD_W-1:0] rb;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode decoder: 4-bit opcode -> one-hot ALU operation, immediate flag and
// illegal flag. With ALU_ISSUE_IMM_EN defined, opcodes 8-15 are immediate
// forms of opcode-8; otherwise they are illegal.
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic [OP_W-1:0]  one_hot,
    output logic             imm,
    output logic             illegal
);

    // Map the base operation, then qualify by the upper opcode bit
    always_comb begin
        one_hot = OP_NONE;
        imm     = FALSE;
        illegal = FALSE;
        case (opcode[2:0])
            OPC_ADD: one_hot = OP_ADD;
            OPC_AND: one_hot = OP_AND;
            OPC_OR:  one_hot = OP_OR;
            OPC_NOT: one_hot = OP_NOT;
            OPC_XOR: one_hot = OP_XOR;
            OPC_SL:  one_hot = OP_SL;
            OPC_SR:  one_hot = OP_SR;
            OPC_CMP: one_hot = OP_CMP;
            default: one_hot = OP_NONE;
        endcase
        if (opcode[3]) begin
`ifdef ALU_ISSUE_IMM_EN
            imm = TRUE;
`else
            one_hot = OP_NONE;
            illegal = TRUE;
`endif
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts one instruction per
// handshake, reads two source registers, drives the ALU for one cycle and
// writes the result back. Sequence IDLE -> READ -> EXEC -> WB.
// Optional build macro: ALU_ISSUE_IMM_EN (immediate forms for opcodes 8-15).
// Operand outputs pass register-file data straight through during EXEC so the
// ALU result can be captured in the same cycle.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 16
)
(
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iInstrValid,
    input  logic [INSTR_W-1:0] iInstr,
    output logic               oInstrReady,
    output logic [REG_AW-1:0]  oRegAddrA,
    output logic [REG_AW-1:0]  oRegAddrB,
    input  logic [DATA_W-1:0]  iRegDataA,
    input  logic [DATA_W-1:0]  iRegDataB,
    output logic [DATA_W-1:0]  oOperandA,
    output logic [DATA_W-1:0]  oOperandB,
    output logic [OP_W-1:0]    oOperation,
    input  logic [DATA_W-1:0]  iAluResult,
    output logic               oWbEn,
    output logic [REG_AW-1:0]  oWbAddr,
    output logic [DATA_W-1:0]  oWbData,
    output logic               oIllegal,
    output logic [CNT_W-1:0]   oRetired
);

    state_t              state_q, state_d;
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [FIELD_W-1:0]  rd_q, rd_d;
    logic [FIELD_W-1:0]  rb_q, rb_d;
    logic [REG_AW-1:0]   addr_a_q, addr_a_d;
    logic [REG_AW-1:0]   addr_b_q, addr_b_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                wb_en_q, wb_en_d;
    logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                illegal_q, illegal_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                ready_q, ready_d;

    instr_t              in_instr;
    logic                accept;
    logic [OPC_W-1:0]    dec_opcode;
    logic [OP_W-1:0]     dec_one_hot;
    logic                dec_imm;
    logic                dec_illegal;

    assign in_instr = instr_t'(iInstr);
    assign accept   = iInstrValid & ready_q;

    // Decode the incoming opcode while idle, the latched opcode otherwise
    assign dec_opcode = (state_q == ST_IDLE) ? in_instr.opcode : opc_q;

    alu_op_decode u_decode (
        .opcode  (dec_opcode),
        .one_hot (dec_one_hot),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        rd_d      = rd_q;
        rb_d      = rb_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        op_d      = OP_NONE;
        wb_en_d   = FALSE;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        illegal_d = FALSE;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_illegal) begin
                        illegal_d = TRUE;
                    end else begin
                        opc_d    = in_instr.opcode;
                        rd_d     = in_instr.rd;
                        rb_d     = in_instr.rb;
                        addr_a_d = REG_AW'(in_instr.ra);
                        addr_b_d = REG_AW'(in_instr.rb);
                        state_d  = ST_READ;
                    end
                end
            end
            ST_READ: begin
                op_d    = dec_one_hot;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                wb_data_d = iAluResult;
                wb_addr_d = REG_AW'(rd_q);
                wb_en_d   = TRUE;
                retired_d = retired_q + CNT_W'(1);
                state_d   = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State register
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs and latched instruction fields
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            opc_q     <= '0;
            rd_q      <= '0;
            rb_q      <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            op_q      <= OP_NONE;
            wb_en_q   <= FALSE;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            illegal_q <= FALSE;
            retired_q <= '0;
            ready_q   <= TRUE;
        end else begin
            opc_q     <= opc_d;
            rd_q      <= rd_d;
            rb_q      <= rb_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            op_q      <= op_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            ready_q   <= ready_d;
        end
    end

    // Operands are live only while the ALU is being driven
    assign oOperandA = (state_q == ST_EXEC) ? iRegDataA : '0;
    assign oOperandB = (state_q != ST_EXEC) ? '0 :
                       dec_imm ? DATA_W'(rb_q) : iRegDataB;

    assign oInstrReady = ready_q;
    assign oRegAddrA   = addr_a_q;
    assign oRegAddrB   = addr_b_q;
    assign oOperation  = op_q;
    assign oWbEn       = wb_en_q;
    assign oWbAddr     = wb_addr_q;
    assign oWbData     = wb_data_q;
    assign oIllegal    = illegal_q;
    assign oRetired    = retired_q;

endmodule
